// File: rtl/avmm_unroll_pkg.sv
// -----------------------------------------------------------------------------
// avmm_unroll_pkg
// Shared definitions for the Avalon-MM burst unroller: controller state
// encoding, default geometry and the outstanding-read counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package avmm_unroll_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_e;

  // Default geometry of the host-memory port
  localparam int DATA_W_DEF      = 512;
  localparam int BEAT_BYTES      = DATA_W_DEF / 8;
  localparam int MAX_PENDING_DEF = 16;

  // Counter must be able to hold the value MAX_PENDING itself
  localparam int PENDING_W = $clog2(MAX_PENDING_DEF + 1);

endpackage : avmm_unroll_pkg

// File: rtl/avmm_credit_counter.sv
// -----------------------------------------------------------------------------
// avmm_credit_counter
// Up/down counter of downstream reads issued but not yet returned.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset, clears the count
//   inc_i        one read issued this cycle
//   dec_i        one read returned this cycle (ignored while count is zero)
//   count_o      current number of outstanding reads
//   can_issue_o  high while count is below MAX_PENDING
// -----------------------------------------------------------------------------
module avmm_credit_counter #(
  parameter int MAX_PENDING = 16,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             can_issue_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             dec_eff_s;

  // A return with nothing outstanding is a protocol error; it must not wrap
  // the counter, so it is discarded here.
  assign dec_eff_s = dec_i && (count_q != '0);

  // Next-state count: issue and return in the same cycle cancel out
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_eff_s) begin
      if (count_q != CNT_W'(MAX_PENDING)) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end else if (dec_eff_s && !inc_i) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign can_issue_o = (count_q < CNT_W'(MAX_PENDING));

endmodule : avmm_credit_counter

// File: rtl/avmm_burst_unroller.sv
// -----------------------------------------------------------------------------
// avmm_burst_unroller
// Converts Avalon-MM burst reads/writes (burstcount 1..8) from the kernel
// system into single-beat accesses on a non-bursting host-memory port. The
// byte address advances by one beat (DATA_W/8 bytes) per access and wraps
// modulo 2^ADDR_W. Read data returns in order through one register stage; a
// credit counter bounds the number of downstream reads in flight.
// Ports (upstream, burst side):
//   s_address/s_read/s_write/s_writedata/s_byteenable/s_burstcount  in
//   s_waitrequest  out  stall of command / write beat
//   s_readdata/s_readdatavalid  out  registered read return
// Ports (downstream, single-beat side):
//   m_address/m_read/m_write/m_writedata/m_byteenable  out
//   m_waitrequest/m_readdata/m_readdatavalid           in
// clk single clock, reset asynchronous active-high.
// -----------------------------------------------------------------------------
module avmm_burst_unroller #(
  parameter int ADDR_W      = 48,
  parameter int DATA_W      = 512,
  parameter int BURST_W     = 4,
  parameter int MAX_PENDING = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic                  s_read,
  input  logic                  s_write,
  input  logic [DATA_W-1:0]     s_writedata,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  input  logic [BURST_W-1:0]    s_burstcount,
  output logic                  s_waitrequest,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid
);

  import avmm_unroll_pkg::*;

  localparam int BEAT_B = DATA_W / 8;
  localparam int CNT_W  = $clog2(MAX_PENDING + 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   beats_left_q, beats_left_d;
  logic [DATA_W-1:0]    rdata_q;
  logic                 rvalid_q;

  logic                 can_issue_s;
  logic [CNT_W-1:0]     pending_s;
  logic                 rd_issue_s;
  logic                 fwd_valid_s;

  // Outstanding-read credit tracking
  avmm_credit_counter #(
    .MAX_PENDING (MAX_PENDING),
    .CNT_W       (CNT_W)
  ) u_credit (
    .clk_i       (clk),
    .rst_i       (reset),
    .inc_i       (rd_issue_s),
    .dec_i       (m_readdatavalid),
    .count_o     (pending_s),
    .can_issue_o (can_issue_s)
  );

  // Next-state, address/beat bookkeeping and handshake outputs
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    beats_left_d  = beats_left_q;
    s_waitrequest = 1'b1;
    m_read        = 1'b0;
    m_write       = 1'b0;
    rd_issue_s    = 1'b0;

    case (state_q)
      IDLE: begin
        // Read wins over write. A read command is taken this cycle; a write
        // only latches its header here and its first beat is accepted in
        // WR_BURST, so the beat stays stalled this cycle.
        if (s_read && !reset) begin
          s_waitrequest = 1'b0;
          addr_d        = s_address;
          beats_left_d  = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
          state_d       = RD_BURST;
        end else if (s_write && !reset) begin
          addr_d        = s_address;
          beats_left_d  = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;
          state_d       = WR_BURST;
        end else begin
          state_d       = IDLE;
        end
      end

      RD_BURST: begin
        m_read     = can_issue_s;
        rd_issue_s = can_issue_s && !m_waitrequest;
        if (rd_issue_s) begin
          addr_d       = addr_q + ADDR_W'(BEAT_B);
          beats_left_d = beats_left_q - BURST_W'(1);
          if (beats_left_q == BURST_W'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          state_d = RD_BURST;
        end
      end

      WR_BURST: begin
        // Beats pass straight through; the downstream stall is reflected
        // upstream only while a beat is actually presented.
        m_write = s_write;
        if (s_write) begin
          s_waitrequest = m_waitrequest;
          if (!m_waitrequest) begin
            addr_d       = addr_q + ADDR_W'(BEAT_B);
            beats_left_d = beats_left_q - BURST_W'(1);
            if (beats_left_q == BURST_W'(1)) begin
              state_d = IDLE;
            end else begin
              state_d = WR_BURST;
            end
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          s_waitrequest = 1'b1;
          state_d       = WR_BURST;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, address and beat counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
    end
  end

  // Returns arriving with nothing outstanding (e.g. stragglers from before a
  // reset) are dropped rather than forwarded upstream.
  assign fwd_valid_s = m_readdatavalid && (pending_s != '0);

  // One-cycle read return register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= m_readdata;
      rvalid_q <= fwd_valid_s;
    end
  end

  assign m_address       = addr_q;
  assign m_writedata     = s_writedata;
  assign m_byteenable    = s_byteenable;
  assign s_readdata      = rdata_q;
  assign s_readdatavalid = rvalid_q;

endmodule : avmm_burst_unroller

// File: tb/tb_avmm_burst_unroller.sv
// -----------------------------------------------------------------------------
// tb_avmm_burst_unroller
// Directed bench with a scoreboard: expected downstream addresses/data and
// expected read returns are queued when stimulus is applied and consumed as
// the DUT produces them. The bench also acts as the downstream memory.
// -----------------------------------------------------------------------------
module tb_avmm_burst_unroller;

  localparam int AW   = 48;
  localparam int DW   = 512;
  localparam int BW   = 4;
  localparam int MAXP = 16;

  logic              clk;
  logic              reset;
  logic [AW-1:0]     s_address;
  logic              s_read;
  logic              s_write;
  logic [DW-1:0]     s_writedata;
  logic [DW/8-1:0]   s_byteenable;
  logic [BW-1:0]     s_burstcount;
  logic              s_waitrequest;
  logic [DW-1:0]     s_readdata;
  logic              s_readdatavalid;
  logic [AW-1:0]     m_address;
  logic              m_read;
  logic              m_write;
  logic [DW-1:0]     m_writedata;
  logic [DW/8-1:0]   m_byteenable;
  logic              m_waitrequest;
  logic [DW-1:0]     m_readdata;
  logic              m_readdatavalid;

  avmm_burst_unroller #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .MAX_PENDING(MAXP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_burstcount    (s_burstcount),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard state
  logic [AW-1:0] exp_ra[$];   // expected downstream read addresses
  logic [AW-1:0] exp_wa[$];   // expected downstream write addresses
  logic [DW-1:0] exp_wd[$];   // expected downstream write data
  logic [DW-1:0] exp_rd[$];   // expected upstream read data
  logic [AW-1:0] resp_q[$];   // reads issued, awaiting a return from the bench
  int            pend_m = 0;  // reference outstanding-read count
  logic          exp_sv = 1'b0;
  int            exp_swait  = -1;  // -1: not checked this cycle
  int            exp_mread  = -1;
  int            exp_mwrite = -1;
  logic          ret_en = 1'b0;
  logic          stray  = 1'b0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{16'hA5C3, a}};
  endfunction

  function automatic logic [DW-1:0] wpat(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {16{kk ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk_i({tag, "_m_read"},          int'(m_read), 0);
    chk_i({tag, "_m_write"},         int'(m_write), 0);
    chk_i({tag, "_s_waitrequest"},   int'(s_waitrequest), 1);
    chk_i({tag, "_s_readdatavalid"}, int'(s_readdatavalid), 0);
    chk_w({tag, "_s_readdata"},      s_readdata, '0);
    chk_w({tag, "_m_address"},       DW'(m_address), '0);
  endtask

  task automatic clear_model();
    exp_ra.delete(); exp_wa.delete(); exp_wd.delete();
    exp_rd.delete(); resp_q.delete();
    pend_m = 0;
    exp_sv = 1'b0;
  endtask

  // One clock cycle: entered at posedge+1 with inputs set. Checks the cycle's
  // outputs, updates the scoreboard, advances one clock, then chooses the
  // bench-memory return for the next cycle.
  task automatic cycle();
    int pb;
    #1;
    pb = pend_m;
    if (exp_swait >= 0)  begin chk_i("s_waitrequest", int'(s_waitrequest), exp_swait); exp_swait = -1; end
    if (exp_mread >= 0)  begin chk_i("m_read", int'(m_read), exp_mread); exp_mread = -1; end
    if (exp_mwrite >= 0) begin chk_i("m_write", int'(m_write), exp_mwrite); exp_mwrite = -1; end
    chk_i("s_readdatavalid", int'(s_readdatavalid), int'(exp_sv));
    if (s_readdatavalid && exp_rd.size() != 0) chk_w("s_readdata", s_readdata, exp_rd.pop_front());
    if (m_read) chk_i("credit_limit", int'(pb < MAXP), 1);
    if (m_read && !m_waitrequest) begin
      chk_i("rd_issue_expected", int'(exp_ra.size() != 0), 1);
      if (exp_ra.size() != 0) chk_w("m_address_rd", DW'(m_address), DW'(exp_ra.pop_front()));
      resp_q.push_back(m_address);
      pend_m++;
    end
    if (m_write && !m_waitrequest) begin
      chk_i("wr_beat_expected", int'(exp_wa.size() != 0), 1);
      if (exp_wa.size() != 0) chk_w("m_address_wr", DW'(m_address), DW'(exp_wa.pop_front()));
      if (exp_wd.size() != 0) chk_w("m_writedata", m_writedata, exp_wd.pop_front());
    end
    exp_sv = m_readdatavalid && (pb > 0);
    if (exp_sv) begin
      exp_rd.push_back(m_readdata);
      pend_m--;
    end
    @(posedge clk);
    #1;
    if (stray) begin
      m_readdatavalid = 1'b1;
      m_readdata      = {8{64'hBAD0_BAD0_BAD0_BAD0}};
      stray           = 1'b0;
    end else if (ret_en && resp_q.size() != 0) begin
      m_readdatavalid = 1'b1;
      m_readdata      = pat(resp_q.pop_front());
    end else begin
      m_readdatavalid = 1'b0;
    end
  endtask

  task automatic push_rd(input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_ra.push_back(a);
      a = a + AW'(64);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (resp_q.size() != 0 || exp_sv || m_readdatavalid); i++) cycle();
    chk_i("drain_resp", resp_q.size(), 0);
    chk_i("drain_rd", exp_rd.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
    s_byteenable = '0; s_burstcount = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    rst_chk("reset");
    reset = 1'b0;
    cycle();

    // Read burst 0x1000 x4, no stalls, immediate returns
    ret_en = 1'b1;
    s_read = 1'b1; s_address = 48'h1000; s_burstcount = 4'd4;
    push_rd(48'h1000, 4);
    exp_swait = 1; exp_mread = 0; exp_swait = 0;
    cycle();
    s_read = 1'b0; s_address = 48'h7777;
    for (int i = 0; i < 4; i++) begin exp_mread = 1; exp_swait = 1; cycle(); end
    exp_mread = 0; cycle();
    drain();

    // Write burst 0x2000 x3, downstream stall on beat 2 for 2 cycles
    s_write = 1'b1; s_address = 48'h2000; s_burstcount = 4'd3;
    s_writedata = wpat(0); s_byteenable = {64{1'b1}};
    exp_wa.push_back(48'h2000); exp_wa.push_back(48'h2040); exp_wa.push_back(48'h2080);
    exp_wd.push_back(wpat(0));  exp_wd.push_back(wpat(1));  exp_wd.push_back(wpat(2));
    exp_swait = 1; exp_mwrite = 0; cycle();
    s_address = 48'hDEAD_0000; s_read = 1'b1; s_burstcount = 4'd7;
    exp_swait = 0; exp_mwrite = 1; cycle();
    s_writedata = wpat(1); m_waitrequest = 1'b1;
    exp_swait = 1; exp_mwrite = 1; cycle();
    exp_swait = 1; cycle();
    m_waitrequest = 1'b0;
    exp_swait = 0; cycle();
    s_writedata = wpat(2);
    exp_swait = 0; cycle();
    s_write = 1'b0; s_read = 1'b0;
    exp_mwrite = 0; exp_swait = 1; cycle();
    chk_i("wr_all_beats", exp_wa.size(), 0);

    // Credit limit: two bursts of 8 with no returns, then a third burst stalls
    ret_en = 1'b0;
    s_read = 1'b1; s_address = 48'h4000; s_burstcount = 4'd8;
    push_rd(48'h4000, 8);
    exp_swait = 0; cycle();
    s_read = 1'b0;
    for (int i = 0; i < 8; i++) begin exp_mread = 1; cycle(); end
    s_read = 1'b1; s_address = 48'h4200; s_burstcount = 4'd8;
    push_rd(48'h4200, 8);
    exp_swait = 0; cycle();
    s_read = 1'b0;
    for (int i = 0; i < 8; i++) begin exp_mread = 1; cycle(); end
    s_read = 1'b1; s_address = 48'h4400; s_burstcount = 4'd2;
    push_rd(48'h4400, 2);
    exp_swait = 0; cycle();
    s_read = 1'b0;
    chk_i("pending_full", pend_m, MAXP);
    exp_mread = 0; cycle();
    exp_mread = 0; cycle();
    ret_en = 1'b1;
    exp_mread = 0; cycle();
    exp_mread = 0; cycle();          // first return arrives, count still 16
    exp_mread = 1; cycle();          // credit freed: issue + return together
    chk_i("pending_steady", pend_m, MAXP - 1);
    exp_mread = 1; cycle();
    exp_mread = 0; cycle();
    drain();
    chk_i("pending_zero", pend_m, 0);

    // Address wrap past all-ones
    s_read = 1'b1; s_address = 48'hFFFF_FFFF_FFC0; s_burstcount = 4'd2;
    push_rd(48'hFFFF_FFFF_FFC0, 2);
    exp_swait = 0; cycle();
    s_read = 1'b0;
    exp_mread = 1; cycle();
    exp_mread = 1; cycle();
    exp_mread = 0; cycle();
    drain();

    // Burstcount 0 behaves as a single beat
    s_read = 1'b1; s_address = 48'h3000; s_burstcount = 4'd0;
    push_rd(48'h3000, 1);
    exp_swait = 0; cycle();
    s_read = 1'b0;
    exp_mread = 1; cycle();
    exp_mread = 0; cycle();
    drain();

    // Reset in the middle of a read burst (2 of 4 issued)
    ret_en = 1'b0;
    s_read = 1'b1; s_address = 48'h5000; s_burstcount = 4'd4;
    push_rd(48'h5000, 4);
    exp_swait = 0; cycle();
    s_read = 1'b0;
    exp_mread = 1; cycle();
    exp_mread = 1; cycle();
    reset = 1'b1;
    #1;
    rst_chk("midburst_reset");
    clear_model();
    cycle();
    cycle();
    reset = 1'b0;
    // A straggling return after reset must be dropped
    stray = 1'b1;
    exp_mread = 0; cycle();
    exp_mread = 0; cycle();
    cycle();

    // Clean burst after reset
    ret_en = 1'b1;
    s_read = 1'b1; s_address = 48'h6000; s_burstcount = 4'd2;
    push_rd(48'h6000, 2);
    exp_swait = 0; cycle();
    s_read = 1'b0;
    exp_mread = 1; cycle();
    exp_mread = 1; cycle();
    exp_mread = 0; cycle();
    drain();
    chk_i("final_ra_empty", exp_ra.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_avmm_burst_unroller
